// File: rtl/fetch_queue.sv
// Instruction fetch front-end: issues ROM reads, buffers returned words with
// their PCs in a small FIFO and hands them to decode over valid/ready.
module fetch_queue #(
    parameter int unsigned    A        = 16,
    parameter int unsigned    W        = 9,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [A-1:0]   RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [A-1:0] start_addr,
    input  logic         redirect,
    input  logic [A-1:0] redirect_addr,
    input  logic         halt,
    output logic         imem_req,
    output logic [A-1:0] imem_addr,
    input  logic [W-1:0] imem_data,
    output logic [W-1:0] inst,
    output logic [A-1:0] inst_pc,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic         idle
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t         state_q, state_d;
    logic [A-1:0]   fetch_pc_q;
    logic [A-1:0]   req_pc_q;
    logic           inflight_q;
    logic           kill_q;
    logic [CW-1:0]  count_q;
    logic [PW-1:0]  rd_ptr_q, wr_ptr_q;

    logic [W-1:0]   inst_mem [DEPTH];
    logic [A-1:0]   pc_mem   [DEPTH];

    logic           flush;
    logic [A-1:0]   new_pc;
    logic           req;
    logic           credit_ok;
    logic           push;
    logic           pop;

    // Outstanding request counts against capacity; a same-cycle pop does not.
    assign credit_ok = (count_q + CW'(inflight_q)) < CW'(DEPTH);

    // Next-state, flush and request decode; start > redirect > halt > fetch.
    always_comb begin
        state_d = state_q;
        flush   = 1'b0;
        new_pc  = fetch_pc_q;
        req     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    flush   = 1'b1;
                    new_pc  = start_addr;
                end
            end
            S_RUN: begin
                if (start) begin
                    flush  = 1'b1;
                    new_pc = start_addr;
                end else if (redirect) begin
                    flush  = 1'b1;
                    new_pc = redirect_addr;
                end else if (halt) begin
                    state_d = S_HALTED;
                end else begin
                    req = credit_ok;
                end
            end
            S_HALTED: begin
                if (start) begin
                    state_d = S_RUN;
                    flush   = 1'b1;
                    new_pc  = start_addr;
                end else begin
                    if (redirect) begin
                        flush  = 1'b1;
                        new_pc = redirect_addr;
                    end
                    if (!halt) begin
                        state_d = S_RUN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign push       = inflight_q & ~kill_q & ~flush;
    assign pop        = (count_q != '0) & inst_ready;

    assign imem_req   = req;
    assign imem_addr  = fetch_pc_q;
    assign inst       = inst_mem[rd_ptr_q];
    assign inst_pc    = pc_mem[rd_ptr_q];
    assign inst_valid = (count_q != '0);
    assign idle       = (state_q != S_RUN) && (count_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch PC, in-flight tracking and queue bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else if (flush) begin
            fetch_pc_q <= new_pc;
            inflight_q <= 1'b0;
            kill_q     <= inflight_q;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            kill_q <= 1'b0;
            if (req) begin
                fetch_pc_q <= fetch_pc_q + A'(1);
                req_pc_q   <= fetch_pc_q;
                inflight_q <= 1'b1;
            end else begin
                inflight_q <= 1'b0;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= imem_data;
            pc_mem[wr_ptr_q]   <= req_pc_q;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: ROM model returns the low address bits as data;
// delivered words are checked against a queue of expected PCs.
module tb_fetch_queue;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] start_addr;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        halt;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [8:0]  imem_data;
    logic [8:0]  inst;
    logic [15:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        idle;

    int          n_tests;
    int          n_fail;
    logic [15:0] exp_q[$];

    fetch_queue dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .start_addr    (start_addr),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt          (halt),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .idle          (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM, one-cycle latency, ROM[i] = i.
    always @(posedge clk) imem_data <= imem_addr[8:0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(16'(base + 16'(i)));
    endtask

    // Scoreboard: every accepted word must be the next expected PC/data pair.
    always @(negedge clk) begin
        if (reset_n && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_pop", {16'h0, inst_pc}, 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", {16'h0, inst_pc}, {16'h0, e});
                chk("sb_inst", {23'h0, inst}, {23'h0, e[8:0]});
            end
        end
    end

    // Stream n sequential fetches from base, then halt and let the queue drain.
    task automatic run_and_halt(input logic [15:0] base, input int n);
        int k;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("req", {31'h0, imem_req}, 32'h1);
            chk("req_addr", {16'h0, imem_addr}, {16'h0, 16'(base + 16'(i))});
            chk("stream_valid", {31'h0, inst_valid}, {31'h0, (i >= 2)});
            tick();
        end
        halt = 1'b1;
        @(negedge clk);
        chk("halt_req", {31'h0, imem_req}, 32'h0);
        tick();
        k = 0;
        while (!idle && k < 20) begin
            tick();
            k++;
        end
        chk("drain_idle", {31'h0, idle}, 32'h1);
        chk("drain_valid", {31'h0, inst_valid}, 32'h0);
        chk("drain_sb", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset_n       = 1'b0;
        start         = 1'b0;
        start_addr    = '0;
        redirect      = 1'b0;
        redirect_addr = '0;
        halt          = 1'b0;
        inst_ready    = 1'b0;

        // Reset state
        #12;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", {16'h0, imem_addr}, 32'h0);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_idle", {31'h0, idle}, 32'h1);
        tick();
        reset_n = 1'b1;
        tick();

        // Streaming from 0x10 with decode always ready
        inst_ready = 1'b1;
        start      = 1'b1;
        start_addr = 16'h0010;
        push_range(16'h0010, 12);
        tick();
        start = 1'b0;
        run_and_halt(16'h0010, 12);

        // Backpressure: queue fills to DEPTH, then resumes without loss
        halt       = 1'b0;
        inst_ready = 1'b0;
        start      = 1'b1;
        start_addr = 16'h0010;
        exp_q.delete();
        push_range(16'h0010, 5);
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("bp_req", {31'h0, imem_req}, {31'h0, (i < 4)});
            if (i < 4) chk("bp_addr", {16'h0, imem_addr}, {16'h0, 16'(16'h0010 + 16'(i))});
            tick();
        end
        @(negedge clk);
        chk("bp_valid", {31'h0, inst_valid}, 32'h1);
        chk("bp_inst", {23'h0, inst}, 32'h10);
        chk("bp_pc", {16'h0, inst_pc}, 32'h10);
        tick();
        inst_ready = 1'b1;
        @(negedge clk);
        chk("bp_nocredit", {31'h0, imem_req}, 32'h0);
        tick();
        @(negedge clk);
        chk("bp_resume", {31'h0, imem_req}, 32'h1);
        chk("bp_resume_addr", {16'h0, imem_addr}, 32'h14);
        tick();
        halt = 1'b1;
        for (int k = 0; k < 20 && !idle; k++) tick();
        chk("bp_idle", {31'h0, idle}, 32'h1);
        chk("bp_sb", 32'(exp_q.size()), 32'h0);

        // Redirect while the 0x13 response is in flight
        halt       = 1'b0;
        inst_ready = 1'b0;
        start      = 1'b1;
        start_addr = 16'h0010;
        exp_q.delete();
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        redirect      = 1'b1;
        redirect_addr = 16'h0040;
        @(negedge clk);
        chk("rd_req", {31'h0, imem_req}, 32'h0);
        tick();
        redirect   = 1'b0;
        inst_ready = 1'b1;
        exp_q.delete();
        push_range(16'h0040, 6);
        run_and_halt(16'h0040, 6);

        // PC wrap from 0xFFFE
        halt       = 1'b0;
        start      = 1'b1;
        start_addr = 16'hFFFE;
        exp_q.delete();
        push_range(16'hFFFE, 6);
        tick();
        start = 1'b0;
        run_and_halt(16'hFFFE, 6);

        // Release halt: resumes at next sequential PC
        halt = 1'b0;
        push_range(16'h0004, 6);
        @(negedge clk);
        chk("resume_wait", {31'h0, imem_req}, 32'h0);
        tick();
        run_and_halt(16'h0004, 6);

        // Async reset mid-stream, redirect ignored in IDLE, then restart
        halt       = 1'b0;
        start      = 1'b1;
        start_addr = 16'h0020;
        exp_q.delete();
        push_range(16'h0020, 16);
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_req", {31'h0, imem_req}, 32'h0);
        chk("arst_valid", {31'h0, inst_valid}, 32'h0);
        chk("arst_idle", {31'h0, idle}, 32'h1);
        chk("arst_addr", {16'h0, imem_addr}, 32'h0);
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        tick();
        redirect      = 1'b1;
        redirect_addr = 16'h0080;
        @(negedge clk);
        chk("idle_redir_req", {31'h0, imem_req}, 32'h0);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("idle_redir_req2", {31'h0, imem_req}, 32'h0);
        chk("idle_redir_idle", {31'h0, idle}, 32'h1);
        tick();
        start      = 1'b1;
        start_addr = 16'h0030;
        push_range(16'h0030, 4);
        tick();
        start = 1'b0;
        run_and_halt(16'h0030, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front-end that sits directly upstream of the decode/control logic in the single-cycle core.
- Generates instruction-ROM addresses and captures 9-bit instruction words from a synchronous ROM with 1-cycle read latency.
- Buffers the words in a small FIFO and presents them, with their PCs, to decode over a valid/ready handshake.
- Handles start, branch redirect (flush) and halt.

Parameters:
- A, 16, instruction address / PC width
- W, 9, instruction word width
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- RESET_PC, 0, fetch PC value after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  sync pulse: flush, load PC from start_addr, begin fetching
- start_addr  in  A  PC loaded on start
- redirect  in  1  taken-branch pulse from decode: flush and refetch
- redirect_addr  in  A  branch target
- halt  in  1  level: stop issuing fetches
- imem_req  out  1  ROM read request this cycle
- imem_addr  out  A  ROM read address (= fetch PC)
- imem_data  in  W  ROM data, valid the cycle after imem_req
- inst  out  W  head-of-queue instruction
- inst_pc  out  A  PC of inst
- inst_valid  out  1  queue non-empty
- inst_ready  in  1  decode accepts inst this cycle
- idle  out  1  FSM in IDLE or HALTED and queue empty

Behaviour:
- Reset (reset_n=0, async):
  - FSM=IDLE, fetch_pc=RESET_PC, count=0, rd/wr pointers=0, inflight=0, kill=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, inst_valid=0, idle=1.
  - inst/inst_pc are don't-care while inst_valid=0.
- FSM states: IDLE, RUN, HALTED.
  - IDLE: no requests. start → RUN; fetch_pc<=start_addr; queue flushed. redirect and halt are ignored.
  - RUN: fetch each cycle per the credit rule. halt=1 → HALTED.
  - HALTED: no requests. The queue keeps draining to decode. start → RUN with flush and PC load. halt deasserted without start → RUN, resuming at the current fetch_pc.
- Priority: start > redirect > halt > normal fetch.
- Fetch rule (RUN only): imem_req = (count + inflight < DEPTH) & ~redirect & ~start & ~halt. Combinational from registered state plus these inputs.
  - Same-cycle pop gives no credit.
- On a request: fetch_pc <= fetch_pc+1, modulo 2^A (wraps from all-ones to 0). inflight<=1 and req_pc<=fetch_pc; otherwise inflight<=0.
- Response (cycle after req, inflight=1):
  - If kill=0: push imem_data with req_pc; count+1.
  - If kill=1: discard.
- Redirect (RUN or HALTED):
  - Flush the queue: count=0, pointers reset, inst_valid=0 next cycle.
  - kill<=inflight, so the current response is dropped.
  - fetch_pc<=redirect_addr. First request to the target occurs next cycle.
  - A pop in the same cycle as redirect is honoured for decode; the queue is still cleared.
- Start: same flush/kill mechanics as redirect, using start_addr.
- Halt: a response already in flight is still written (not killed).
- Pop: inst_valid & inst_ready → rd_ptr+1, count−1.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- Invariants:
  - Overflow is impossible by the credit rule. An assertion flags a push while count==DEPTH.
  - Pop on empty is ignored.
- Throughput: back-to-back, 1 instruction per cycle when inst_ready is held high.
- Latency: 2 cycles from start to inst_valid: request in cycle after start, data captured next edge.
- kill clears after one cycle.

Test Plan:
1. Reset, start with start_addr=0x0010, inst_ready=1, ROM[i]=i → imem_addr 0x10,0x11,…, one per cycle. inst_valid rises 2 cycles after start. inst/inst_pc stream 0x10,0x11,… with no gaps.
2. inst_ready=0 after start → exactly 4 requests (0x10..0x13), then imem_req=0, count=4, inst=0x10 held. Raise inst_ready → fetching resumes at 0x14, no word lost or duplicated.
3. Redirect to 0x0040 while a request for 0x13 is in flight → 0x13 word discarded, inst_valid=0 next cycle. Next imem_addr=0x40; next inst_pc seen =0x40.
4. start_addr=0xFFFE, inst_ready=1 → PCs 0xFFFE,0xFFFF,0x0000,0x0001 (wrap).
5. halt asserted mid-stream with a request in flight → imem_req=0 from that cycle, in-flight word still delivered. Queue drains; idle=1 once empty. Deassert halt → fetch resumes at next sequential PC.
6. reset_n pulsed low mid-stream (asynchronously, between edges) → immediate imem_req=0, inst_valid=0, idle=1. redirect in IDLE is ignored. start re-launches correctly.
